// File: rtl/pe_pkg.sv
// Shared types and helpers for the BRAM port arbiter: FSM state encoding,
// BRAM address width and the round-robin pick function.
package pe_pkg;

    localparam int BRAM_AW = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // First requester at or after last+1 (mod n); sized for up to 8 requesters.
    function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                           input logic [2:0] last,
                                           input int         n);
        logic [2:0] pick;
        int         idx;
        pick = last;
        for (int k = 8; k >= 1; k--) begin
            if (k <= n) begin
                idx = (int'(last) + k) % n;
                if (req[idx]) begin
                    pick = 3'(idx);
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester-side bus of the BRAM port arbiter: per-requester request,
// address/data/byte-enables, grant and read return.
interface bram_port_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]                  req;
    logic [NUM_REQ-1:0]                  gnt;
    logic [NUM_REQ*pe_pkg::BRAM_AW-1:0]  req_addr;
    logic [NUM_REQ*32-1:0]               req_wrdata;
    logic [NUM_REQ*4-1:0]                req_we;
    logic [31:0]                         rddata;
    logic [NUM_REQ-1:0]                  rvalid;

    modport master (
        output req, req_addr, req_wrdata, req_we,
        input  gnt, rddata, rvalid
    );

    modport slave (
        input  req, req_addr, req_wrdata, req_we,
        output gnt, rddata, rvalid
    );
endinterface

// File: rtl/bram_rd_return.sv
// Read-return pipeline: a RD_LAT-deep shift of {valid, requester index}
// decoded into a per-requester rvalid that lines up with BRAM read data.
module bram_rd_return #(
    parameter  int NUM_REQ = 4,
    parameter  int RD_LAT  = 1,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               in_valid,
    input  logic [IW-1:0]      in_idx,
    output logic [NUM_REQ-1:0] rvalid
);

    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [IW-1:0]     idx_q [RD_LAT];
    logic [IW-1:0]     idx_d [RD_LAT];

    always_comb begin
        vld_d = '0;
        for (int k = 0; k < RD_LAT; k++) begin
            idx_d[k] = '0;
        end
        vld_d[0] = in_valid;
        idx_d[0] = in_idx;
        for (int k = 1; k < RD_LAT; k++) begin
            vld_d[k] = vld_q[k-1];
            idx_d[k] = idx_q[k-1];
        end
    end

    // Reset drops anything in flight, so no stale pulse survives a mid-burst reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            vld_q <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                idx_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < RD_LAT; k++) begin
                idx_q[k] <= idx_d[k];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rvalid
            assign rvalid[gi] = vld_q[RD_LAT-1] && (idx_q[RD_LAT-1] == IW'(gi));
        end
    endgenerate

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port among NUM_REQ controllers, with
// burst hold and bounded burst. Optional BRAM_ARB_STATS_EN adds stat_wait_max.
module bram_port_arbiter
    import pe_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 64,
    parameter int RD_LAT    = 1
) (
    input  logic                aclk,
    input  logic                aresetn,
    bram_port_arbiter_if.slave  rq,
    output logic [BRAM_AW-1:0]  BRAM_ADDR,
    output logic [31:0]         BRAM_WRDATA,
    output logic [3:0]          BRAM_WE,
    output logic                BRAM_EN,
    input  logic [31:0]         BRAM_RDDATA
`ifdef BRAM_ARB_STATS_EN
    ,output logic [16*NUM_REQ-1:0] stat_wait_max
`endif
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [IW-1:0]      last_q, last_d;
    logic [CW-1:0]      burst_cnt_q, burst_cnt_d;
    logic [DW-1:0]      drain_cnt_q, drain_cnt_d;

    logic [IW-1:0]      pick;
    logic               granted;
    logic               others;

    assign pick    = IW'(rr_pick(8'(rq.req), 3'(last_q), NUM_REQ));
    assign granted = (state_q == S_GRANT) && rq.req[gidx_q] && gnt_q[gidx_q];
    // gnt_q is one-hot on the holder while granting, so this masks it out.
    assign others  = |(rq.req & ~gnt_q);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gidx_d      = gidx_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (|rq.req) begin
                    state_d     = S_GRANT;
                    gnt_d       = NUM_REQ'(1) << pick;
                    gidx_d      = pick;
                    last_d      = pick;
                    burst_cnt_d = '0;
                end
            end
            S_GRANT: begin
                if (!granted) begin
                    state_d     = S_DRAIN;
                    gnt_d       = '0;
                    drain_cnt_d = '0;
                end else begin
                    if (burst_cnt_q != CW'(MAX_BURST)) begin
                        burst_cnt_d = burst_cnt_q + CW'(1);
                    end
                    // >= so a saturated uncontested burst still yields once someone asks.
                    if ((burst_cnt_q >= CW'(MAX_BURST - 1)) && others) begin
                        state_d     = S_DRAIN;
                        gnt_d       = '0;
                        drain_cnt_d = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DW'(RD_LAT - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            gidx_q      <= '0;
            last_q      <= IW'(NUM_REQ - 1);
            burst_cnt_q <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gidx_q      <= gidx_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    always_comb begin
        BRAM_ADDR   = '0;
        BRAM_WRDATA = '0;
        BRAM_WE     = '0;
        BRAM_EN     = 1'b0;
        if (state_q == S_GRANT) begin
            BRAM_ADDR   = rq.req_addr[int'(gidx_q)*BRAM_AW +: BRAM_AW];
            BRAM_WRDATA = rq.req_wrdata[int'(gidx_q)*32 +: 32];
            if (granted) begin
                BRAM_EN = 1'b1;
                BRAM_WE = rq.req_we[int'(gidx_q)*4 +: 4];
            end
        end
    end

    assign rq.gnt    = gnt_q;
    assign rq.rddata = BRAM_RDDATA;

    bram_rd_return #(
        .NUM_REQ (NUM_REQ),
        .RD_LAT  (RD_LAT)
    ) u_rd_return (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .in_valid (granted && (rq.req_we[int'(gidx_q)*4 +: 4] == 4'h0)),
        .in_idx   (gidx_q),
        .rvalid   (rq.rvalid)
    );

`ifdef BRAM_ARB_STATS_EN
    logic [NUM_REQ-1:0] req_prev_q, req_prev_d;
    logic [NUM_REQ-1:0] armed_q, armed_d;
    logic [15:0]        wait_cnt_q [NUM_REQ];
    logic [15:0]        wait_cnt_d [NUM_REQ];
    logic [15:0]        wait_max_q [NUM_REQ];
    logic [15:0]        wait_max_d [NUM_REQ];

    // A wait is armed by a req rising edge and closed by the first grant seen.
    always_comb begin
        req_prev_d = rq.req;
        armed_d    = armed_q;
        wait_cnt_d = wait_cnt_q;
        wait_max_d = wait_max_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
                if (armed_q[i] && (wait_cnt_q[i] > wait_max_q[i])) begin
                    wait_max_d[i] = wait_cnt_q[i];
                end
                armed_d[i] = 1'b0;
            end else if (rq.req[i] && !req_prev_q[i]) begin
                armed_d[i]    = 1'b1;
                wait_cnt_d[i] = 16'd1;
            end else if (armed_q[i] && rq.req[i] && (wait_cnt_q[i] != 16'hFFFF)) begin
                wait_cnt_d[i] = wait_cnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            req_prev_q <= '0;
            armed_q    <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt_q[i] <= '0;
                wait_max_q[i] <= '0;
            end
        end else begin
            req_prev_q <= req_prev_d;
            armed_q    <= armed_d;
            wait_cnt_q <= wait_cnt_d;
            wait_max_q <= wait_max_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_stat
            assign stat_wait_max[gi*16 +: 16] = wait_max_q[gi];
        end
    endgenerate
`endif

endmodule
